fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC register, the instruction-memory request/response handshake and the IF/ID pipeline register.
- Consumes the hazard unit's PCEn/IFIDEn stall controls and the branch/jump redirect from the pipeline.
- Feeds the decode stage with {valid, pc, instr}.
- Allows one outstanding imem request; a response arriving during a stall is buffered, not lost.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on bubble/flush (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- pc_en  input  1  PC update enable from hazard unit
- ifid_en  input  1  IF/ID register enable from hazard unit
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_pc  input  XLEN  redirect target
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address
- imem_resp_valid  input  1  instruction returned (one-cycle pulse, never before the cycle after acceptance)
- imem_resp_data  input  XLEN  instruction word
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_pc  output  XLEN  PC of IF/ID instruction
- ifid_instr  output  XLEN  IF/ID instruction

Behaviour:
- Reset (rst=1 at posedge, overrides everything, any state):
  - pc=RESET_PC, state=IDLE, hold buffer cleared.
  - ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR.
  - imem_req_valid=0 during the reset cycle.
  - Any in-flight response after reset is ignored: the memory must not respond to a request issued before reset.
- States: IDLE, WAIT, HOLD, DROP.
- Combinational request outputs:
  - imem_req_valid = (state==IDLE) && !redirect_valid && !rst.
  - imem_req_addr = pc.
- transfer = pc_en && ifid_en.
- IDLE:
  - req_valid && req_ready -> WAIT; pc unchanged (pc is the address of the outstanding fetch).
- WAIT:
  - resp_valid && transfer -> IF/ID <= {1, pc, resp_data}; pc <= pc+4 (mod 2^XLEN, wraps); -> IDLE.
  - resp_valid && !transfer -> store resp_data in hold buffer; -> HOLD.
  - No response -> stay WAIT.
- HOLD:
  - transfer -> IF/ID <= {1, pc, buffer}; pc <= pc+4; -> IDLE.
  - Otherwise stay.
- DROP:
  - resp_valid -> discard data; -> IDLE.
  - Otherwise stay.
- redirect_valid (priority over all of the above except reset), ignoring pc_en:
  - pc <= redirect_pc.
  - IF/ID <= {0, 0, NOP_INSTR}.
  - From WAIT -> DROP. From DROP without resp -> stay DROP. From DROP with resp -> IDLE. From HOLD -> IDLE, buffer discarded. From IDLE -> IDLE, no request issued that cycle.
- IF/ID update when no redirect and no fetch transfer:
  - ifid_en=1 -> IF/ID <= bubble {0, 0, NOP_INSTR}.
  - ifid_en=0 -> IF/ID holds all fields.
- Timing:
  - Best-case throughput: one instruction per 2 cycles (request cycle + response cycle).
  - Latency from request acceptance to ifid_valid: response latency + 1 cycle.
- Misaligned redirect_pc is fetched as-is; alignment checking belongs to the execute stage.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - Adds output fetch_stall_cnt (32 bits), reset to 0.
  - Increments by 1 (wrapping) on every cycle with state==HOLD, or state==WAIT && !imem_resp_valid.
  - Redirect does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then single-cycle memory (ready=1, resp one cycle after accept, instr=0x00100093):
  - ifid_valid rises with ifid_pc=0x0, instr=0x00100093.
  - Subsequent fetches at 0x4, 0x8; a new ifid_valid every 2 cycles.
- Stall on response (pc_en=ifid_en=0 in response cycle, held 3 cycles):
  - state HOLD; IF/ID unchanged; no new request.
  - On release, IF/ID gets the buffered word, pc advances by 4, exactly once.
- Redirect in WAIT (redirect_pc=0x100):
  - Stale response discarded; IF/ID becomes bubble.
  - Next request address 0x100; first valid ifid_pc=0x100.
- Redirect in IDLE with req_ready=1:
  - imem_req_valid=0 that cycle.
  - Next cycle requests 0x100.
- Reset asserted mid-WAIT:
  - All outputs return to reset values next cycle; next request at RESET_PC.
- PC wrap (redirect_pc=0xFFFF_FFFC):
  - After the fetch, next request address 0x0000_0000.
  - With FETCH_STALL_CNT_EN and 2-cycle response latency, counter +1 per fetch.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem handshake, IF/ID register; optional FETCH_STALL_CNT_EN stall counter.
// Latency: request accept -> ifid_valid = memory response latency + 1 cycle; best case one instruction per 2 cycles.
// Backpressure: pc_en/ifid_en low parks a returned word in a hold buffer and suppresses new requests until transfer.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    input  logic            ifid_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]     fetch_stall_cnt,
`endif
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetchState_t;

    fetchState_t     state;
    fetchState_t     stateNext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] holdBuf;
    logic [XLEN-1:0] holdNext;
    logic            ifidValidNext;
    logic [XLEN-1:0] ifidPcNext;
    logic [XLEN-1:0] ifidInstrNext;
    logic            fetchDone;
    logic [XLEN-1:0] fetchWord;
    logic            transfer;

    assign transfer       = pc_en && ifid_en;
    assign imem_req_valid = (state == S_IDLE) && !redirect_valid && !rst;
    assign imem_req_addr  = pc;

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        holdNext      = holdBuf;
        ifidValidNext = ifid_valid;
        ifidPcNext    = ifid_pc;
        ifidInstrNext = ifid_instr;
        fetchDone     = 1'b0;
        fetchWord     = imem_resp_data;

        if (redirect_valid) begin
            // A fetch still in flight must have its response swallowed in DROP.
            pcNext        = redirect_pc;
            ifidValidNext = 1'b0;
            ifidPcNext    = '0;
            ifidInstrNext = NOP_INSTR;
            unique case (state)
                S_WAIT:  stateNext = S_DROP;
                S_DROP:  stateNext = imem_resp_valid ? S_IDLE : S_DROP;
                default: stateNext = S_IDLE;
            endcase
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (imem_req_valid && imem_req_ready) begin
                        stateNext = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (transfer) begin
                            fetchDone = 1'b1;
                            stateNext = S_IDLE;
                        end else begin
                            holdNext  = imem_resp_data;
                            stateNext = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    fetchWord = holdBuf;
                    if (transfer) begin
                        fetchDone = 1'b1;
                        stateNext = S_IDLE;
                    end
                end
                default: begin
                    if (imem_resp_valid) begin
                        stateNext = S_IDLE;
                    end
                end
            endcase

            if (fetchDone) begin
                ifidValidNext = 1'b1;
                ifidPcNext    = pc;
                ifidInstrNext = fetchWord;
                pcNext        = pc + XLEN'(4);
            end else if (ifid_en) begin
                ifidValidNext = 1'b0;
                ifidPcNext    = '0;
                ifidInstrNext = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            holdBuf    <= '0;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            holdBuf    <= holdNext;
            ifid_valid <= ifidValidNext;
            ifid_pc    <= ifidPcNext;
            ifid_instr <= ifidInstrNext;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_stall_cnt <= '0;
        end else if ((state == S_HOLD) || ((state == S_WAIT) && !imem_resp_valid)) begin
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural instruction memory and an in-order scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        ifid_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] fetch_stall_cnt;
    logic [31:0] cntStart;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    int lat = 1;
    int pendCnt = 0;
    logic [31:0] pendAddr = '0;
    logic frozen = 1'b0;
    logic [63:0] sb[$];

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef FETCH_STALL_CNT_EN
        .fetch_stall_cnt (fetch_stall_cnt),
`endif
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_instr      (ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h0010_0093 ^ {a[23:0], 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory model plus scoreboard pop, all evaluated 1 time unit after the edge.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        logic        wasRst;
        logic [63:0] e;
        #1;
        acc    = imem_req_valid && imem_req_ready;
        a      = imem_req_addr;
        wasRst = rst;
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
        if (wasRst) begin
            pendCnt = 0;
        end else begin
            if (pendCnt > 0) begin
                pendCnt--;
                if (pendCnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memWord(pendAddr);
                end
            end
            if (acc) begin
                sb.push_back({a, memWord(a)});
                pendAddr = a;
                if (lat == 1) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memWord(a);
                end else begin
                    pendCnt = lat - 1;
                end
            end
        end
        if (!frozen && ifid_valid === 1'b1) begin
            check("valid_has_expected", 32'(ifid_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ifid_pc", ifid_pc, e[63:32]);
                check("ifid_instr", ifid_instr, e[31:0]);
                delivered++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pc_en = 1'b1;
        ifid_en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'hDEAD_BEEF;

        // Reset state
        step();
        step();
        check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_ifid_instr", ifid_instr, NOP);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall_cnt", fetch_stall_cnt, 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Single-cycle memory: four fetches in eight cycles
        for (int i = 0; i < 8; i++) step();
        check("stream_count", 32'(delivered), 32'd4);
        check("stream_next_addr", imem_req_addr, 32'h10);

        // Stall while the response arrives, held three cycles
        step();
        pc_en = 1'b0;
        ifid_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_req_valid", 32'(imem_req_valid), 32'd0);
            check("hold_ifid_valid", 32'(ifid_valid), 32'd0);
            check("hold_ifid_instr", ifid_instr, NOP);
        end
        pc_en = 1'b1;
        ifid_en = 1'b1;
        step();
        check("hold_release_count", 32'(delivered), 32'd5);
        check("hold_release_addr", imem_req_addr, 32'h14);

        // Redirect while waiting on a two-cycle memory
        lat = 2;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        sb.delete();
        step();
        redirect_valid = 1'b0;
        check("drop_ifid_valid", 32'(ifid_valid), 32'd0);
        check("drop_ifid_instr", ifid_instr, NOP);
        check("drop_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        check("drop_done_ifid_valid", 32'(ifid_valid), 32'd0);
        check("after_drop_req_valid", 32'(imem_req_valid), 32'd1);
        check("after_drop_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 3; i++) step();
        check("redirect_fetch_count", 32'(delivered), 32'd6);

        // Redirect in IDLE suppresses the request that cycle
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("idle_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("idle_redirect_next_valid", 32'(imem_req_valid), 32'd1);
        check("idle_redirect_next_addr", imem_req_addr, 32'h100);
        check("idle_redirect_count", 32'(delivered), 32'd6);

        // Reset in the middle of WAIT with a valid word frozen in IF/ID
        step();
        step();
        check("pre_reset_count", 32'(delivered), 32'd7);
        pc_en = 1'b0;
        ifid_en = 1'b0;
        frozen = 1'b1;
        lat = 2;
        step();
        check("frozen_ifid_valid", 32'(ifid_valid), 32'd1);
        check("frozen_ifid_pc", ifid_pc, 32'h100);
        rst = 1'b1;
        sb.delete();
        step();
        check("midrst_ifid_valid", 32'(ifid_valid), 32'd0);
        check("midrst_ifid_pc", ifid_pc, 32'd0);
        check("midrst_ifid_instr", ifid_instr, NOP);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        pc_en = 1'b1;
        ifid_en = 1'b1;
        frozen = 1'b0;
        #1;
        check("midrst_next_valid", 32'(imem_req_valid), 32'd1);
        check("midrst_next_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 3; i++) step();
        check("post_reset_count", 32'(delivered), 32'd8);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        #1;
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
`ifdef FETCH_STALL_CNT_EN
        cntStart = fetch_stall_cnt;
`endif
        for (int i = 0; i < 3; i++) step();
        check("wrap_count", 32'(delivered), 32'd9);
        check("wrap_next_addr", imem_req_addr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt_delta", fetch_stall_cnt - cntStart, 32'd1);
`endif
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
